// File: rtl/pkg_tpu.sv
// Shared TPU scalar-unit definitions: hazard-window operand/entry types, default sizes
// and the pending-slot state encoding. RAR checking is enabled with `define HAZARD_RAR_EN.
package pkg_tpu;

  localparam int unsigned HZ_IDX_W          = 8;
  localparam int unsigned HZ_NUM_SRC        = 3;
  localparam int unsigned NUM_ENTRY_HAZARD  = 8;
  localparam int unsigned NUM_COMMIT_HAZARD = 2;

  // Operand index is {is_vec, regfile no, reg idx}; v marks the operand as used.
  typedef struct packed {
    logic                v;
    logic [HZ_IDX_W-1:0] idx;
  } hz_opnd_t;

  typedef struct {
    hz_opnd_t dst;
    hz_opnd_t src[HZ_NUM_SRC];
  } hz_entry_t;

  typedef enum logic {
    HZ_EMPTY = 1'b0,
    HZ_CHECK = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_match_row.sv
// Per-entry comparator: one in-flight record versus the pending instruction.
// The source/source (RAR) compare is only built when HAZARD_RAR_EN is defined.
module hazard_match_row
  import pkg_tpu::*;
#(
  parameter int unsigned IDX_W   = HZ_IDX_W,
  parameter int unsigned NUM_SRC = HZ_NUM_SRC
) (
  input  logic                         ent_v,
  input  logic [IDX_W:0]               ent_dst,
  input  logic [NUM_SRC*(IDX_W+1)-1:0] ent_src,
  input  logic [IDX_W:0]               pnd_dst,
  input  logic [NUM_SRC*(IDX_W+1)-1:0] pnd_src,
  output logic                         raw,
  output logic                         war,
  output logic                         waw,
  output logic                         rar
);

  localparam int unsigned OW = IDX_W + 1;

  function automatic logic op_eq(input logic [IDX_W:0] a, input logic [IDX_W:0] b);
    return a[IDX_W] & b[IDX_W] & (a[IDX_W-1:0] == b[IDX_W-1:0]);
  endfunction

  always_comb begin
    raw = 1'b0;
    war = 1'b0;
    waw = 1'b0;
    rar = 1'b0;
    if (ent_v) begin
      waw = op_eq(pnd_dst, ent_dst);
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        raw = raw | op_eq(pnd_src[i*OW +: OW], ent_dst);
        war = war | op_eq(pnd_dst, ent_src[i*OW +: OW]);
`ifdef HAZARD_RAR_EN
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
          rar = rar | op_eq(pnd_src[i*OW +: OW], ent_src[j*OW +: OW]);
        end
`endif
      end
    end
  end

endmodule

// File: rtl/hazard_window_tpu.sv
// One-deep pending slot checked for RAW/WAR/WAW (and RAR with HAZARD_RAR_EN) against an
// in-flight table; allocates lowest free tag on issue, frees by tag on NUM_COMMIT ports.
module hazard_window_tpu
  import pkg_tpu::*;
#(
  parameter int unsigned NUM_ENTRY  = NUM_ENTRY_HAZARD,
  parameter int unsigned NUM_SRC    = HZ_NUM_SRC,
  parameter int unsigned NUM_COMMIT = NUM_COMMIT_HAZARD,
  parameter int unsigned IDX_W      = HZ_IDX_W,
  parameter int unsigned TAG_W      = $clog2(NUM_ENTRY)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          I_Req,
  output logic                          O_Ready,
  input  logic                          I_Slice,
  input  logic [IDX_W:0]                I_Dst,
  input  logic [NUM_SRC*(1+IDX_W)-1:0]  I_Src,
  input  logic [NUM_COMMIT-1:0]         I_Commit_Req,
  input  logic [NUM_COMMIT*TAG_W-1:0]   I_Commit_Tag,
  output logic                          O_Req_Issue,
  output logic [TAG_W-1:0]              O_Tag,
  output logic                          O_RAW_Hazard,
  output logic                          O_WAR_Hazard,
  output logic                          O_WAW_Hazard,
  output logic                          O_RAR_Hazard,
  output logic                          O_Full,
  output logic [TAG_W:0]                O_Num,
  output logic [15:0]                   O_Stall_Cnt,
  output logic                          O_Err
);

  localparam int unsigned OW = IDX_W + 1;
  localparam int unsigned SW = NUM_SRC * OW;
  localparam int unsigned CW = TAG_W + 1;

  hz_state_e            state_q, state_d;
  logic                 out_en_q;
  logic [OW-1:0]        pend_dst_q, pend_dst_d;
  logic [SW-1:0]        pend_src_q, pend_src_d;
  logic                 pend_slice_q, pend_slice_d;
  logic [NUM_ENTRY-1:0] ent_v_q, ent_v_d;
  logic [OW-1:0]        ent_dst_q [NUM_ENTRY];
  logic [OW-1:0]        ent_dst_d [NUM_ENTRY];
  logic [SW-1:0]        ent_src_q [NUM_ENTRY];
  logic [SW-1:0]        ent_src_d [NUM_ENTRY];
  logic                 issue_q, issue_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 raw_q, raw_d, war_q, war_d, waw_q, waw_d, rar_q, rar_d;
  logic [CW-1:0]        num_q, num_d;
  logic [15:0]          stall_q, stall_d;
  logic                 err_q, err_d;

  logic                 pend_v, full, ready, accept, issue_now, slice_in;
  logic                 raw_any, war_any, waw_any, rar_any, bad_commit;
  logic [NUM_ENTRY-1:0] raw_vec, war_vec, waw_vec, rar_vec, clr_mask;
  logic [TAG_W-1:0]     free_idx, cmt_tag;
  logic [CW-1:0]        clr_cnt;

  for (genvar e = 0; e < NUM_ENTRY; e++) begin : g_row
    hazard_match_row #(
      .IDX_W   (IDX_W),
      .NUM_SRC (NUM_SRC)
    ) u_row (
      .ent_v   (ent_v_q[e]),
      .ent_dst (ent_dst_q[e]),
      .ent_src (ent_src_q[e]),
      .pnd_dst (pend_dst_q),
      .pnd_src (pend_src_q),
      .raw     (raw_vec[e]),
      .war     (war_vec[e]),
      .waw     (waw_vec[e]),
      .rar     (rar_vec[e])
    );
  end

`ifdef HAZARD_RAR_EN
  always_comb slice_in = I_Slice;
`else
  logic unused_slice;
  always_comb slice_in = 1'b0;
  always_comb unused_slice = I_Slice;
`endif

  always_comb begin
    pend_v    = (state_q == HZ_CHECK);
    full      = &ent_v_q;
    raw_any   = |raw_vec;
    war_any   = |war_vec;
    waw_any   = |waw_vec;
    rar_any   = pend_slice_q & (|rar_vec);
    issue_now = pend_v & ~(raw_any | war_any | waw_any | rar_any) & ~full;
    ready     = out_en_q & (~pend_v | issue_now);
    accept    = I_Req & ready;

    // Descending scan so the lowest free index wins.
    free_idx = '0;
    for (int unsigned e = NUM_ENTRY; e > 0; e--) begin
      if (!ent_v_q[e-1]) free_idx = TAG_W'(e - 1);
    end

    // Commits look only at the pre-edge valid mask; a duplicate tag sets the same bit.
    clr_mask   = '0;
    bad_commit = 1'b0;
    cmt_tag    = '0;
    for (int unsigned p = 0; p < NUM_COMMIT; p++) begin
      cmt_tag = I_Commit_Tag[p*TAG_W +: TAG_W];
      if (I_Commit_Req[p]) begin
        if (ent_v_q[cmt_tag]) clr_mask[cmt_tag] = 1'b1;
        else                  bad_commit        = 1'b1;
      end
    end
    clr_cnt = '0;
    for (int unsigned e = 0; e < NUM_ENTRY; e++) begin
      clr_cnt = clr_cnt + CW'(clr_mask[e]);
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_dst_d   = pend_dst_q;
    pend_src_d   = pend_src_q;
    pend_slice_d = pend_slice_q;
    case (state_q)
      HZ_EMPTY: if (accept) state_d = HZ_CHECK;
      HZ_CHECK: if (issue_now && !accept) state_d = HZ_EMPTY;
      default:  state_d = HZ_EMPTY;
    endcase
    if (accept) begin
      pend_dst_d   = I_Dst;
      pend_src_d   = I_Src;
      pend_slice_d = slice_in;
    end

    ent_v_d   = ent_v_q & ~clr_mask;
    ent_dst_d = ent_dst_q;
    ent_src_d = ent_src_q;
    if (issue_now) begin
      ent_v_d[free_idx]   = 1'b1;
      ent_dst_d[free_idx] = pend_dst_q;
      ent_src_d[free_idx] = pend_src_q;
    end

    issue_d = issue_now;
    tag_d   = issue_now ? free_idx : tag_q;
    raw_d   = pend_v & raw_any;
    war_d   = pend_v & war_any;
    waw_d   = pend_v & waw_any;
    rar_d   = pend_v & rar_any;
    num_d   = num_q + CW'(issue_now) - clr_cnt;
    stall_d = (pend_v && !issue_now && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    err_d   = err_q | bad_commit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= HZ_EMPTY;
      out_en_q     <= 1'b0;
      pend_dst_q   <= '0;
      pend_src_q   <= '0;
      pend_slice_q <= 1'b0;
      ent_v_q      <= '0;
      for (int unsigned e = 0; e < NUM_ENTRY; e++) begin
        ent_dst_q[e] <= '0;
        ent_src_q[e] <= '0;
      end
      issue_q <= 1'b0;
      tag_q   <= '0;
      raw_q   <= 1'b0;
      war_q   <= 1'b0;
      waw_q   <= 1'b0;
      rar_q   <= 1'b0;
      num_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_en_q     <= 1'b1;
      pend_dst_q   <= pend_dst_d;
      pend_src_q   <= pend_src_d;
      pend_slice_q <= pend_slice_d;
      ent_v_q      <= ent_v_d;
      ent_dst_q    <= ent_dst_d;
      ent_src_q    <= ent_src_d;
      issue_q      <= issue_d;
      tag_q        <= tag_d;
      raw_q        <= raw_d;
      war_q        <= war_d;
      waw_q        <= waw_d;
      rar_q        <= rar_d;
      num_q        <= num_d;
      stall_q      <= stall_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    O_Ready      = ready;
    O_Req_Issue  = issue_q;
    O_Tag        = tag_q;
    O_RAW_Hazard = raw_q;
    O_WAR_Hazard = war_q;
    O_WAW_Hazard = waw_q;
    O_RAR_Hazard = rar_q;
    O_Full       = full;
    O_Num        = num_q;
    O_Stall_Cnt  = stall_q;
    O_Err        = err_q;
  end

endmodule

// File: tb/tb_hazard_window_tpu.sv
// Self-checking bench for hazard_window_tpu: vector tables plus hand-written sequences,
// with a tag scoreboard popped on every issue pulse. Follows HAZARD_RAR_EN if defined.
module tb_hazard_window_tpu;
  import pkg_tpu::*;

  localparam int unsigned NE = 8;
  localparam int unsigned NS = 3;
  localparam int unsigned NC = 2;
  localparam int unsigned IW = 8;
  localparam int unsigned TW = 3;
  localparam int unsigned OW = IW + 1;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 I_Req;
  logic                 O_Ready;
  logic                 I_Slice;
  logic [OW-1:0]        I_Dst;
  logic [NS*OW-1:0]     I_Src;
  logic [NC-1:0]        I_Commit_Req;
  logic [NC*TW-1:0]     I_Commit_Tag;
  logic                 O_Req_Issue;
  logic [TW-1:0]        O_Tag;
  logic                 O_RAW_Hazard, O_WAR_Hazard, O_WAW_Hazard, O_RAR_Hazard;
  logic                 O_Full;
  logic [TW:0]          O_Num;
  logic [15:0]          O_Stall_Cnt;
  logic                 O_Err;

  always #5 clock = ~clock;

  hazard_window_tpu #(
    .NUM_ENTRY  (NE),
    .NUM_SRC    (NS),
    .NUM_COMMIT (NC),
    .IDX_W      (IW),
    .TAG_W      (TW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .I_Req        (I_Req),
    .O_Ready      (O_Ready),
    .I_Slice      (I_Slice),
    .I_Dst        (I_Dst),
    .I_Src        (I_Src),
    .I_Commit_Req (I_Commit_Req),
    .I_Commit_Tag (I_Commit_Tag),
    .O_Req_Issue  (O_Req_Issue),
    .O_Tag        (O_Tag),
    .O_RAW_Hazard (O_RAW_Hazard),
    .O_WAR_Hazard (O_WAR_Hazard),
    .O_WAW_Hazard (O_WAW_Hazard),
    .O_RAR_Hazard (O_RAR_Hazard),
    .O_Full       (O_Full),
    .O_Num        (O_Num),
    .O_Stall_Cnt  (O_Stall_Cnt),
    .O_Err        (O_Err)
  );

  int checks = 0;
  int errors = 0;
  logic [TW-1:0] sb[$];
  logic [TW-1:0] sb_exp;
  int exp_stall;

  typedef struct {
    logic [OW-1:0] dst, s0, s1, s2;
    logic [TW-1:0] tag;
    logic [TW:0]   num;
    logic          full;
  } iss_vec_t;

  typedef struct {
    logic [OW-1:0] dst, s0, s1;
    logic          raw, war, waw;
    logic [TW-1:0] ctag, tag;
  } hz_vec_t;

  iss_vec_t iv[8];
  hz_vec_t  hv[4];

  function automatic logic [OW-1:0] op(input logic v, input int idx);
    hz_opnd_t o;
    o.v   = v;
    o.idx = IW'(idx);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [OW-1:0] d, input logic [OW-1:0] s0,
                      input logic [OW-1:0] s1, input logic [OW-1:0] s2, input logic sl);
    I_Req   = 1'b1;
    I_Dst   = d;
    I_Src   = {s2, s1, s0};
    I_Slice = sl;
    tick();
    I_Req   = 1'b0;
    I_Slice = 1'b0;
  endtask

  task automatic commit2(input logic r0, input logic [TW-1:0] t0,
                         input logic r1, input logic [TW-1:0] t1);
    I_Commit_Req = {r1, r0};
    I_Commit_Tag = {t1, t0};
    tick();
    I_Commit_Req = '0;
  endtask

  task automatic chk_flags(input string name, input logic raw, input logic war,
                           input logic waw, input logic rar);
    chk({name, "_raw"}, O_RAW_Hazard, raw);
    chk({name, "_war"}, O_WAR_Hazard, war);
    chk({name, "_waw"}, O_WAW_Hazard, waw);
    chk({name, "_rar"}, O_RAR_Hazard, rar);
  endtask

  // Every issue pulse must match the oldest expected tag.
  always @(negedge clock) begin
    if (reset === 1'b1 && O_Req_Issue === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_issue: got tag %0d expected no issue", O_Tag);
      end else begin
        sb_exp = sb.pop_front();
        if (O_Tag !== sb_exp) begin
          errors++;
          $display("FAIL sb_tag: got %0d expected %0d", O_Tag, sb_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    iv[0] = '{op(1, 5), op(1, 1), op(1, 2), '0, 3'd0, 4'd1, 1'b0};
    for (int i = 1; i < 8; i++)
      iv[i] = '{op(1, 10 + i), op(1, 40 + i), op(1, 60 + i), '0, TW'(i), 4'(i + 1), (i == 7)};
    hv[0] = '{op(1, 30), op(1, 5),  '0,        1'b1, 1'b0, 1'b0, 3'd0, 3'd0};
    hv[1] = '{op(1, 41), op(1, 80), '0,        1'b0, 1'b1, 1'b0, 3'd1, 3'd1};
    hv[2] = '{op(1, 14), op(1, 81), '0,        1'b0, 1'b0, 1'b1, 3'd4, 3'd2};
    hv[3] = '{op(1, 82), op(0, 30), op(1, 20), 1'b1, 1'b0, 1'b0, 3'd3, 3'd3};

    reset = 1'b0;
    I_Req = 1'b0; I_Slice = 1'b0; I_Dst = '0; I_Src = '0;
    I_Commit_Req = '0; I_Commit_Tag = '0;
    tick(); tick();
    chk("rst_ready", O_Ready, 0);
    chk("rst_issue", O_Req_Issue, 0);
    chk("rst_num", O_Num, 0);
    chk("rst_full", O_Full, 0);
    chk_flags("rst", 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_ready", O_Ready, 1);
    chk("post_rst_stall", O_Stall_Cnt, 0);
    chk("post_rst_err", O_Err, 0);

    // Independent issues fill the table; each issues two cycles after the request.
    for (int i = 0; i < 8; i++) begin
      chk("iss_ready", O_Ready, 1);
      sb.push_back(iv[i].tag);
      send(iv[i].dst, iv[i].s0, iv[i].s1, iv[i].s2, 1'b0);
      chk("iss_not_early", O_Req_Issue, 0);
      tick();
      chk("iss_pulse", O_Req_Issue, 1);
      chk("iss_num", O_Num, iv[i].num);
      chk("iss_full", O_Full, iv[i].full);
      chk_flags("iss", 0, 0, 0, 0);
    end

    // Ninth instruction blocks on full; commit tag 3 on port 1 releases it.
    send(op(1, 20), op(1, 70), '0, '0, 1'b0);
    tick(); tick(); tick();
    chk("full_stall_cnt", O_Stall_Cnt, 3);
    chk("full_ready", O_Ready, 0);
    chk("full_no_issue", O_Req_Issue, 0);
    chk_flags("full", 0, 0, 0, 0);
    sb.push_back(3'd3);
    commit2(1'b0, 3'd0, 1'b1, 3'd3);
    chk("full_commit_cycle_no_issue", O_Req_Issue, 0);
    chk("full_cleared", O_Full, 0);
    chk("full_num_after_commit", O_Num, 7);
    tick();
    chk("full_release_issue", O_Req_Issue, 1);
    chk("full_release_num", O_Num, 8);
    chk("full_again", O_Full, 1);
    chk("full_stall_final", O_Stall_Cnt, 4);

    // Duplicate tag on both ports frees once; commit to a free tag is flagged.
    commit2(1'b1, 3'd2, 1'b1, 3'd2);
    chk("dup_num", O_Num, 7);
    chk("dup_err", O_Err, 0);
    commit2(1'b1, 3'd6, 1'b0, 3'd0);
    chk("c6_num", O_Num, 6);
    commit2(1'b1, 3'd6, 1'b0, 3'd0);
    chk("bogus_err", O_Err, 1);
    chk("bogus_num", O_Num, 6);
    tick(); tick();
    chk("bogus_err_sticky", O_Err, 1);

    exp_stall = 4;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(hv[i].tag);
      send(hv[i].dst, hv[i].s0, hv[i].s1, '0, 1'b0);
      tick();
      chk_flags("hz", hv[i].raw, hv[i].war, hv[i].waw, 0);
      chk("hz_no_issue", O_Req_Issue, 0);
      chk("hz_ready", O_Ready, 0);
      commit2(1'b1, hv[i].ctag, 1'b0, 3'd0);
      chk("hz_commit_cycle_no_issue", O_Req_Issue, 0);
      chk("hz_ready_on_release", O_Ready, 1);
      tick();
      exp_stall += 2;
      chk("hz_release_issue", O_Req_Issue, 1);
      chk_flags("hz_clear", 0, 0, 0, 0);
      chk("hz_stall", O_Stall_Cnt, exp_stall);
      chk("hz_num", O_Num, 6);
    end

    // Source/source matching: only a sliced instruction stalls, and only with the feature.
    commit2(1'b1, 3'd5, 1'b1, 3'd7);
    chk("pre_rar_num", O_Num, 4);
    sb.push_back(3'd4);
    send(op(1, 90), op(1, 9), '0, '0, 1'b0);
    tick();
    chk("rar_base_issue", O_Req_Issue, 1);
    sb.push_back(3'd5);
    send(op(1, 92), op(1, 9), '0, '0, 1'b0);
    tick();
    chk("rar_unsliced_issue", O_Req_Issue, 1);
    chk("rar_unsliced_flag", O_RAR_Hazard, 0);
    chk("rar_unsliced_num", O_Num, 6);
`ifdef HAZARD_RAR_EN
    sb.push_back(3'd4);
    send(op(1, 91), op(1, 9), '0, '0, 1'b1);
    tick();
    chk_flags("rar_sliced", 0, 0, 0, 1);
    chk("rar_sliced_no_issue", O_Req_Issue, 0);
    commit2(1'b1, 3'd4, 1'b1, 3'd5);
    chk("rar_commit_cycle_no_issue", O_Req_Issue, 0);
    tick();
    chk("rar_release_issue", O_Req_Issue, 1);
    chk("rar_release_flag", O_RAR_Hazard, 0);
    chk("rar_release_num", O_Num, 5);
`else
    sb.push_back(3'd6);
    send(op(1, 91), op(1, 9), '0, '0, 1'b1);
    tick();
    chk("rar_off_issue", O_Req_Issue, 1);
    chk("rar_off_flag", O_RAR_Hazard, 0);
    chk("rar_off_num", O_Num, 7);
`endif

    // Asynchronous reset while a RAW stall is held.
    send(op(1, 93), op(1, 30), '0, '0, 1'b0);
    tick();
    chk("ar_raw", O_RAW_Hazard, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_raw_clr", O_RAW_Hazard, 0);
    chk("ar_num", O_Num, 0);
    chk("ar_stall", O_Stall_Cnt, 0);
    chk("ar_err", O_Err, 0);
    chk("ar_ready", O_Ready, 0);
    chk("ar_issue", O_Req_Issue, 0);
    reset = 1'b1;
    tick();
    chk("ar_post_ready", O_Ready, 1);
    chk("ar_post_num", O_Num, 0);
    chk("ar_post_stall", O_Stall_Cnt, 0);
    sb.push_back(3'd0);
    send(op(1, 93), op(1, 30), '0, '0, 1'b0);
    tick();
    chk("ar_fresh_issue", O_Req_Issue, 1);
    chk("ar_fresh_num", O_Num, 1);
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_window_tpu.md
Name: hazard_window_tpu

Overview:
- Parametrised successor of the TPU scalar-unit hazard checker.
- Holds one pending instruction and checks it for RAW/WAR/WAW hazards against an in-flight table of NUM_ENTRY operand records. Optionally also checks RAR for sliced operation.
- Allocates the lowest free tag on issue. Frees entries by tag on any of NUM_COMMIT commit ports, so completion may be out of order.
- Sits between the instruction fetch/decode stage and the scalar/vector dispatch stage.

Parameters:
- NUM_ENTRY, 8: in-flight table depth; power of two, at least 2.
- NUM_SRC, 3: source operands per instruction, 1..3.
- NUM_COMMIT, 2: independent commit ports.
- IDX_W, 8: operand index width, formed as {is_vec, regfile no, reg idx}.
- TAG_W, $clog2(NUM_ENTRY): tag width.

Ports:
- clock in 1: clock.
- reset in 1: asynchronous, active-low reset.
- I_Req in 1: instruction valid.
- O_Ready out 1: the pending slot can accept an instruction.
- I_Slice in 1: slicing mode for this instruction.
- I_Dst in 1+IDX_W: destination {v, idx}.
- I_Src in NUM_SRC*(1+IDX_W): sources {v, idx}; source 0 occupies the LSBs.
- I_Commit_Req in NUM_COMMIT: commit strobes.
- I_Commit_Tag in NUM_COMMIT*TAG_W: tags to free.
- O_Req_Issue out 1: one-cycle issue pulse.
- O_Tag out TAG_W: tag allocated to the issued instruction.
- O_RAW_Hazard, O_WAR_Hazard, O_WAW_Hazard, O_RAR_Hazard out 1 each: registered hazard status of the pending instruction.
- O_Full out 1: all entries are valid.
- O_Num out TAG_W+1: in-flight count.
- O_Stall_Cnt out 16: saturating count of stalled cycles.
- O_Err out 1: sticky flag, set by a commit to a free entry.

Behaviour:
- Reset: all outputs 0, every table entry invalid, pending slot empty, O_Ready = 1 on the first cycle after reset release.
- Acceptance:
  - O_Ready = ~pend_v | issue_now.
  - I_Req & O_Ready captures the operands into the pending register at the next edge.
- Pending-slot FSM:
  - States: EMPTY, CHECK.
  - EMPTY -> CHECK on accept.
  - CHECK -> EMPTY on issue_now without a new accept.
  - CHECK -> CHECK on a stall, or on issue plus a back-to-back accept.
- Hazard evaluation is combinational on the pending register versus all valid entries.
  - RAW: a pending src.v matches an entry dst.v with equal idx.
  - WAR: a pending dst.v matches any entry src.v with equal idx.
  - WAW: dst against dst.
  - RAR (feature only): pending I_Slice and any src/src match.
- issue_now = pend_v & ~(RAW|WAR|WAW|RAR) & ~Full.
- On issue_now:
  - The entry at the priority-encoded lowest free index receives {dst, src} at the next edge.
  - O_Req_Issue = 1 and O_Tag = that index in the following cycle.
  - Issue latency is 2 cycles from the accept edge when hazard-free.
- Hazard outputs are registered every cycle while pend_v, and cleared when the slot is empty.
- Commit:
  - Each valid port clears the named entry's valid bits at the next edge.
  - The table is registered, so a hazard being cleared still blocks in the commit cycle; the earliest issue is the cycle after.
  - Duplicate tags on two ports in one cycle clear the entry once.
  - A commit to an invalid entry is ignored and sets O_Err until reset.
- Simultaneous commit and allocate: allocation uses only the pre-edge free mask. A tag committed this cycle becomes allocatable from the next cycle.
- O_Num update: O_Num += issue_now - (number of distinct valid commits to valid entries), all in one edge.
- Full: issue is blocked and O_Full = 1. A commit in the same cycle unblocks from the next cycle.
- O_Stall_Cnt increments when pend_v & ~issue_now, and saturates at 16'hFFFF.
- Asserting reset mid-operation drops the pending instruction and all entries immediately.

Optional Feature:
- Macro: HAZARD_RAR_EN.
- Defined: RAR compare is built in. A sliced pending instruction stalls on any source-to-source match, and O_RAR_Hazard reflects it.
- Undefined: no RAR logic is built, O_RAR_Hazard is tied to 0, and I_Slice is ignored.

Decomposition:
- Shared package pkg_tpu gains:
  - typedef hz_opnd_t {logic v; logic [IDX_W-1:0] idx}.
  - typedef hz_entry_t {hz_opnd_t dst; hz_opnd_t src[NUM_SRC]}.
  - Constants NUM_ENTRY_HAZARD and NUM_COMMIT_HAZARD.
- One sub-module, hazard_match_row: per-entry comparator producing raw/war/waw/rar bits for a single entry versus the pending instruction. It is instantiated NUM_ENTRY times, and the results are OR-reduced.

Test Plan:
- Independent issue: reset, then I_Req with dst=5, src=1,2, empty table -> O_Req_Issue at cycle +2, O_Tag=0, O_Num=1, all hazard flags 0.
- RAW stall and release: entry tag0 holds dst=5; pending src0=5 -> O_RAW_Hazard=1 and O_Stall_Cnt counts. Commit tag0 at cycle t -> issue pulse at t+2, O_Tag=0.
- Full blocking: 8 independent issues with no commits -> O_Full=1 and the 9th stalls. Commit tag 3 on port 1 -> the 9th issues with O_Tag=3.
- Dual commit, duplicate and bogus tags: commit tag2 on ports 0 and 1 -> O_Num drops by 1. Commit free tag6 -> O_Err=1 stays set; O_Num unchanged.
- RAR with HAZARD_RAR_EN: entry src=9; pending sliced src=9 -> O_RAR_Hazard=1 and stall. Same stimulus with the macro undefined, or I_Slice=0 -> issues in 2 cycles.
- Async reset mid-stall: assert reset low while a stall is active -> outputs 0 immediately. After release, O_Ready=1, O_Num=0, O_Stall_Cnt=0.
